mrd_rdx_wrback: RTL and testbench

Write-back stage directly downstream of the radix-2/3/4/5 butterfly + twiddle stage of the mixed-radix DFT engine. Accepts one butterfly result per valid cycle (up to 5 complex lanes, each tagged with a destination bank index and bank address), routes each lane through a 5×5 crossbar onto the write port of its target memory bank, and counts completed butterflies so the stage controller knows when a radix pass has been fully written back. Flags bank conflicts, illegal bank indices and overrun writes.

---
 rtl/mrd_pkg.sv | 27 ++
 rtl/mrd_rdx_wrback_if.sv | 38 +++
 rtl/mrd_wr_xbar.sv | 61 ++++++
 rtl/mrd_rdx_wrback.sv | 164 ++++++++++++++++
 tb/tb_mrd_rdx_wrback.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mrd_pkg.sv
// Shared types and sizing for the mixed-radix DFT write-back stage.
package mrd_pkg;

    localparam int wDataInOut = 30;
    localparam int NUM_BANK   = 5;
    localparam int wAddr      = 8;
    localparam int wCnt       = 10;
    localparam int wIdx       = 3;
    localparam int wFactor    = 3;

    // One complex sample; packed order gives the {real, imag} write word.
    typedef struct packed {
        logic [wDataInOut-1:0] re;
        logic [wDataInOut-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A lane carries data only when its number is below the current radix.
    function automatic logic lane_active(input int lane, input logic [wFactor-1:0] factor);
        return lane < int'(factor);
    endfunction

endpackage

// File: rtl/mrd_rdx_wrback_if.sv
// Butterfly-result input bus, bank write ports and pass status of the write-back stage.
interface mrd_rdx_wrback_if;
    import mrd_pkg::*;

    logic                                     stage_start;
    logic [wCnt-1:0]                          num_bfly;
    logic [wFactor-1:0]                       factor;
    logic                                     in_valid;
    logic [0:NUM_BANK-1][wDataInOut-1:0]      in_d_real;
    logic [0:NUM_BANK-1][wDataInOut-1:0]      in_d_imag;
    logic [0:NUM_BANK-1][wIdx-1:0]            in_bank_index;
    logic [0:NUM_BANK-1][wAddr-1:0]           in_bank_addr;

    logic [NUM_BANK-1:0]                      wr_en;
    logic [0:NUM_BANK-1][wAddr-1:0]           wr_addr;
    logic [0:NUM_BANK-1][2*wDataInOut-1:0]    wr_data;

    logic                                     busy;
    logic                                     stage_done;
    logic                                     err_conflict;
    logic                                     err_bank;
    logic                                     err_overrun;

    modport master (
        output stage_start, num_bfly, factor, in_valid,
               in_d_real, in_d_imag, in_bank_index, in_bank_addr,
        input  wr_en, wr_addr, wr_data,
               busy, stage_done, err_conflict, err_bank, err_overrun
    );

    modport slave (
        input  stage_start, num_bfly, factor, in_valid,
               in_d_real, in_d_imag, in_bank_index, in_bank_addr,
        output wr_en, wr_addr, wr_data,
               busy, stage_done, err_conflict, err_bank, err_overrun
    );

endinterface

// File: rtl/mrd_wr_xbar.sv
// Registered 5x5 lane-to-bank crossbar. The lowest-numbered active lane wins a
// bank; losing lanes and lanes with an out-of-range bank index are dropped.
// Detection flags are combinational so the caller can register them on the
// same edge as the write ports.
module mrd_wr_xbar
    import mrd_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [wFactor-1:0]                factor,
    input  cplx_t [0:NUM_BANK-1]              lane_data,
    input  logic [0:NUM_BANK-1][wIdx-1:0]     lane_index,
    input  logic [0:NUM_BANK-1][wAddr-1:0]    lane_addr,
    output logic [NUM_BANK-1:0]               wr_en,
    output logic [0:NUM_BANK-1][wAddr-1:0]    wr_addr,
    output cplx_t [0:NUM_BANK-1]              wr_data,
    output logic                              conflict_det,
    output logic                              bank_det
);

    logic [NUM_BANK-1:0]              sel_en;
    logic [0:NUM_BANK-1][wAddr-1:0]   sel_addr;
    cplx_t [0:NUM_BANK-1]             sel_data;

    // Walk lanes in ascending order so the first claim on a bank sticks.
    always_comb begin
        sel_en       = '0;
        sel_addr     = '0;
        sel_data     = '0;
        conflict_det = 1'b0;
        bank_det     = 1'b0;
        for (int l = 0; l < NUM_BANK; l++) begin
            if (in_valid && lane_active(l, factor)) begin
                if (int'(lane_index[l]) >= NUM_BANK) begin
                    bank_det = 1'b1;
                end else if (sel_en[lane_index[l]]) begin
                    conflict_det = 1'b1;
                end else begin
                    sel_en[lane_index[l]]   = 1'b1;
                    sel_addr[lane_index[l]] = lane_addr[l];
                    sel_data[lane_index[l]] = lane_data[l];
                end
            end
        end
    end

    // Bank write ports are registered; reset flushes any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= sel_en;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end
    end

endmodule

// File: rtl/mrd_rdx_wrback.sv
// Write-back stage after the butterfly/twiddle stage: input register, crossbar
// onto the bank write ports, butterfly counting per radix pass, sticky errors.
//
//   state | meaning
//   IDLE  | no pass armed; beats are written but flagged as overrun
//   RUN   | pass armed, counting accepted butterflies down to the last one
//
// The butterfly count is a down-counter loaded with num_bfly; the beat seen
// while it holds 1 is the final one of the pass.
module mrd_rdx_wrback
    import mrd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mrd_rdx_wrback_if.slave   bus
);

    state_t                           state, state_nxt;
    logic [wCnt-1:0]                  remain, remain_nxt;
    logic                             last_beat;
    logic                             zero_done;
    logic                             overrun;

    logic                             s1_valid;
    logic [wFactor-1:0]               s1_factor;
    cplx_t [0:NUM_BANK-1]             s1_data;
    logic [0:NUM_BANK-1][wIdx-1:0]    s1_index;
    logic [0:NUM_BANK-1][wAddr-1:0]   s1_addr;
    logic                             s1_done;
    logic                             s1_overrun;

    logic                             stage_done_q;
    logic                             err_conflict_q;
    logic                             err_bank_q;
    logic                             err_overrun_q;

    logic [NUM_BANK-1:0]              xb_en;
    logic [0:NUM_BANK-1][wAddr-1:0]   xb_addr;
    cplx_t [0:NUM_BANK-1]             xb_data;
    logic                             xb_conflict;
    logic                             xb_bank;

    // FSM state and remaining-butterfly counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    // Next state; stage_start overrides the current pass and may itself carry
    // the first beat of the new pass.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        last_beat  = 1'b0;
        zero_done  = 1'b0;
        overrun    = 1'b0;
        if (bus.stage_start) begin
            if (bus.num_bfly == '0) begin
                state_nxt  = IDLE;
                remain_nxt = '0;
                zero_done  = 1'b1;
            end else if (bus.in_valid && (bus.num_bfly == wCnt'(1))) begin
                state_nxt  = IDLE;
                remain_nxt = '0;
                last_beat  = 1'b1;
            end else begin
                state_nxt  = RUN;
                remain_nxt = bus.in_valid ? (bus.num_bfly - wCnt'(1)) : bus.num_bfly;
            end
        end else begin
            case (state)
                IDLE: overrun = bus.in_valid;
                RUN: begin
                    if (bus.in_valid) begin
                        if (remain == wCnt'(1)) begin
                            state_nxt  = IDLE;
                            remain_nxt = '0;
                            last_beat  = 1'b1;
                        end else begin
                            remain_nxt = remain - wCnt'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage 1: capture the beat plus its completion/overrun tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_factor  <= '0;
            s1_data    <= '0;
            s1_index   <= '0;
            s1_addr    <= '0;
            s1_done    <= 1'b0;
            s1_overrun <= 1'b0;
        end else begin
            s1_valid   <= bus.in_valid;
            s1_factor  <= bus.factor;
            s1_index   <= bus.in_bank_index;
            s1_addr    <= bus.in_bank_addr;
            s1_done    <= last_beat | zero_done;
            s1_overrun <= overrun;
            for (int l = 0; l < NUM_BANK; l++) begin
                s1_data[l].re <= bus.in_d_real[l];
                s1_data[l].im <= bus.in_d_imag[l];
            end
        end
    end

    mrd_wr_xbar u_xbar (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (s1_valid),
        .factor       (s1_factor),
        .lane_data    (s1_data),
        .lane_index   (s1_index),
        .lane_addr    (s1_addr),
        .wr_en        (xb_en),
        .wr_addr      (xb_addr),
        .wr_data      (xb_data),
        .conflict_det (xb_conflict),
        .bank_det     (xb_bank)
    );

    // Stage 2: done pulse and sticky errors line up with the crossbar writes;
    // a new pass wipes errors left over from the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_done_q   <= 1'b0;
            err_conflict_q <= 1'b0;
            err_bank_q     <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            stage_done_q <= s1_done;
            if (bus.stage_start) begin
                err_conflict_q <= 1'b0;
                err_bank_q     <= 1'b0;
                err_overrun_q  <= 1'b0;
            end else begin
                err_conflict_q <= err_conflict_q | xb_conflict;
                err_bank_q     <= err_bank_q | xb_bank;
                err_overrun_q  <= err_overrun_q | s1_overrun;
            end
        end
    end

    assign bus.wr_en        = xb_en;
    assign bus.wr_addr      = xb_addr;
    assign bus.wr_data      = xb_data;
    assign bus.busy         = (state == RUN);
    assign bus.stage_done   = stage_done_q;
    assign bus.err_conflict = err_conflict_q;
    assign bus.err_bank     = err_bank_q;
    assign bus.err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_mrd_rdx_wrback.sv
// Directed bench for the write-back stage: pass counting, crossbar routing,
// error flags, abort/restart and asynchronous reset.
module tb_mrd_rdx_wrback;
    import mrd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mrd_rdx_wrback_if bus ();

    mrd_rdx_wrback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] pk(input int k, input int l);
        logic [29:0] re;
        logic [29:0] im;
        re = 30'(k * 256 + l + 1);
        im = 30'(32'h2000_0000 + k * 16 + l);
        return {re, im};
    endfunction

    function automatic logic [7:0] ad(input int k, input int l);
        return 8'(10 + l + 32 * k);
    endfunction

    task automatic set_beat(input int k, input logic [2:0] fac, input logic [0:4][2:0] idx);
        logic [59:0] w;
        bus.factor   = fac;
        bus.in_valid = 1'b1;
        for (int l = 0; l < 5; l++) begin
            w = pk(k, l);
            bus.in_d_real[l]     = w[59:30];
            bus.in_d_imag[l]     = w[29:0];
            bus.in_bank_index[l] = idx[l];
            bus.in_bank_addr[l]  = ad(k, l);
        end
    endtask

    task automatic start(input logic [9:0] n);
        bus.stage_start = 1'b1;
        bus.num_bfly    = n;
    endtask

    task automatic idle_in();
        bus.stage_start = 1'b0;
        bus.in_valid    = 1'b0;
    endtask

    initial begin
        bus.stage_start   = 1'b0;
        bus.num_bfly      = '0;
        bus.factor        = 3'd5;
        bus.in_valid      = 1'b0;
        bus.in_d_real     = '0;
        bus.in_d_imag     = '0;
        bus.in_bank_index = '0;
        bus.in_bank_addr  = '0;

        // reset values
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_wr_en", bus.wr_en, 5'b0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'h0);
        check("rst_wr_data0", bus.wr_data[0], 60'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.stage_done, 1'b0);
        check("rst_errs", {bus.err_conflict, bus.err_bank, bus.err_overrun}, 3'b000);
        #4 rst_n = 1'b1;
        tick();

        // radix-5 pass of 3 butterflies, all lanes to their own bank
        start(10'd3);
        bus.factor = 3'd5;
        tick();
        check("t1_busy_rise", bus.busy, 1'b1);
        bus.stage_start = 1'b0;
        set_beat(0, 3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        tick();
        set_beat(1, 3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        tick();
        check("t1_wr_en_b0", bus.wr_en, 5'b11111);
        for (int l = 0; l < 5; l++) begin
            check($sformatf("t1_addr%0d", l), bus.wr_addr[l], ad(0, l));
            check($sformatf("t1_data%0d", l), bus.wr_data[l], pk(0, l));
        end
        check("t1_done_b0", bus.stage_done, 1'b0);
        set_beat(2, 3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        tick();
        check("t1_wr_en_b1", bus.wr_en, 5'b11111);
        check("t1_data3_b1", bus.wr_data[3], pk(1, 3));
        check("t1_busy_fall", bus.busy, 1'b0);
        check("t1_done_b1", bus.stage_done, 1'b0);
        idle_in();
        tick();
        check("t1_wr_en_b2", bus.wr_en, 5'b11111);
        check("t1_data4_b2", bus.wr_data[4], pk(2, 4));
        check("t1_done_b2", bus.stage_done, 1'b1);
        tick();
        check("t1_wr_en_off", bus.wr_en, 5'b0);
        check("t1_done_off", bus.stage_done, 1'b0);

        // radix-3: inactive lanes 3,4 aim at bank 0 but must be ignored
        start(10'd1);
        bus.factor = 3'd3;
        tick();
        check("t2_busy", bus.busy, 1'b1);
        bus.stage_start = 1'b0;
        set_beat(3, 3'd3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0});
        tick();
        check("t2_busy_fall", bus.busy, 1'b0);
        idle_in();
        tick();
        check("t2_wr_en", bus.wr_en, 5'b00111);
        check("t2_data0", bus.wr_data[0], pk(3, 0));
        check("t2_data1", bus.wr_data[1], pk(3, 1));
        check("t2_data2", bus.wr_data[2], pk(3, 2));
        check("t2_conflict", bus.err_conflict, 1'b0);
        check("t2_done", bus.stage_done, 1'b1);
        tick();

        // radix-4 conflict: lanes 1 and 2 both to bank 2, lane 1 wins
        start(10'd2);
        bus.factor = 3'd4;
        tick();
        bus.stage_start = 1'b0;
        set_beat(4, 3'd4, {3'd0, 3'd2, 3'd2, 3'd3, 3'd0});
        tick();
        idle_in();
        tick();
        check("t3_wr_en", bus.wr_en, 5'b01101);
        check("t3_data2", bus.wr_data[2], pk(4, 1));
        check("t3_addr2", bus.wr_addr[2], ad(4, 1));
        check("t3_conflict", bus.err_conflict, 1'b1);
        check("t3_bank", bus.err_bank, 1'b0);
        check("t3_done_first", bus.stage_done, 1'b0);
        set_beat(5, 3'd4, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        tick();
        idle_in();
        tick();
        check("t3_wr_en_clean", bus.wr_en, 5'b01111);
        check("t3_data2_clean", bus.wr_data[2], pk(5, 2));
        check("t3_conflict_sticky", bus.err_conflict, 1'b1);
        check("t3_done", bus.stage_done, 1'b1);
        tick();
        check("t3_conflict_hold", bus.err_conflict, 1'b1);
        start(10'd5);
        tick();
        bus.stage_start = 1'b0;
        check("t3_conflict_clr", bus.err_conflict, 1'b0);
        check("t3_busy", bus.busy, 1'b1);

        // illegal bank index on lane 0, then an overrun beat in IDLE
        start(10'd1);
        bus.factor = 3'd2;
        tick();
        bus.stage_start = 1'b0;
        set_beat(6, 3'd2, {3'd6, 3'd1, 3'd0, 3'd0, 3'd0});
        tick();
        idle_in();
        tick();
        check("t4_wr_en", bus.wr_en, 5'b00010);
        check("t4_data1", bus.wr_data[1], pk(6, 1));
        check("t4_bank", bus.err_bank, 1'b1);
        check("t4_conflict", bus.err_conflict, 1'b0);
        check("t4_done", bus.stage_done, 1'b1);
        tick();
        set_beat(7, 3'd2, {3'd3, 3'd4, 3'd0, 3'd0, 3'd0});
        tick();
        idle_in();
        tick();
        check("t4_ovr_wr_en", bus.wr_en, 5'b11000);
        check("t4_ovr_data3", bus.wr_data[3], pk(7, 0));
        check("t4_ovr_data4", bus.wr_data[4], pk(7, 1));
        check("t4_overrun", bus.err_overrun, 1'b1);
        check("t4_bank_sticky", bus.err_bank, 1'b1);
        check("t4_ovr_busy", bus.busy, 1'b0);
        check("t4_ovr_done", bus.stage_done, 1'b0);

        // abort: 4-butterfly pass restarted after 2 beats with num_bfly=2
        start(10'd4);
        bus.factor = 3'd2;
        tick();
        check("t5_ovr_clr", bus.err_overrun, 1'b0);
        check("t5_bank_clr", bus.err_bank, 1'b0);
        check("t5_busy", bus.busy, 1'b1);
        bus.stage_start = 1'b0;
        set_beat(8, 3'd2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        tick();
        set_beat(9, 3'd2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        tick();
        start(10'd2);
        set_beat(10, 3'd2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        check("t5_done_b8", bus.stage_done, 1'b0);
        tick();
        bus.stage_start = 1'b0;
        set_beat(11, 3'd2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
        check("t5_done_b9", bus.stage_done, 1'b0);
        check("t5_busy_restart", bus.busy, 1'b1);
        tick();
        idle_in();
        check("t5_done_b10", bus.stage_done, 1'b0);
        check("t5_data0_b10", bus.wr_data[0], pk(10, 0));
        check("t5_busy_fall", bus.busy, 1'b0);
        tick();
        check("t5_done_b11", bus.stage_done, 1'b1);
        check("t5_data1_b11", bus.wr_data[1], pk(11, 1));
        tick();
        check("t5_done_off", bus.stage_done, 1'b0);

        // empty pass: done pulses two cycles after stage_start
        start(10'd0);
        tick();
        bus.stage_start = 1'b0;
        check("t6_busy", bus.busy, 1'b0);
        check("t6_done_early", bus.stage_done, 1'b0);
        tick();
        check("t6_done", bus.stage_done, 1'b1);
        tick();
        check("t6_done_off", bus.stage_done, 1'b0);

        // asynchronous reset with beats in flight
        start(10'd10);
        bus.factor = 3'd5;
        tick();
        bus.stage_start = 1'b0;
        set_beat(12, 3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        tick();
        set_beat(13, 3'd5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        tick();
        check("t7_wr_en_pre", bus.wr_en, 5'b11111);
        check("t7_busy_pre", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_wr_en_rst", bus.wr_en, 5'b0);
        check("t7_busy_rst", bus.busy, 1'b0);
        check("t7_data0_rst", bus.wr_data[0], 60'h0);
        check("t7_addr_rst", 64'(bus.wr_addr), 64'h0);
        idle_in();
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("t7_wr_en_post1", bus.wr_en, 5'b0);
        tick();
        check("t7_wr_en_post2", bus.wr_en, 5'b0);
        check("t7_busy_post", bus.busy, 1'b0);
        check("t7_done_post", bus.stage_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
